// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIT stage sequencer: point-size encoding,
// FSM state encoding and the butterfly address helper.
package fft_pkg;

    localparam int AW_C      = 9;
    localparam int WAW_C     = 8;
    localparam int ROM_DEPTH = 256;
    localparam int M_BASE    = 6;   // np=0 selects 64 points, so M = 6 + np
    localparam int M_MAX     = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [AW_C-1:0]  a1;
        logic [AW_C-1:0]  a2;
        logic [WAW_C-1:0] wn;
    } bf_addr_t;

    function automatic logic [3:0] np_to_m(input logic [1:0] np);
        return 4'(M_BASE) + {2'b00, np};
    endfunction

    // Index of the last butterfly in a stage, N/2 - 1.
    function automatic logic [7:0] last_bf(input logic [3:0] m);
        logic [8:0] half;
        half = 9'd1 << (m - 4'd1);
        return 8'(half - 9'd1);
    endfunction

    // Twiddles are indexed in W512 units, so the ROM shift depends only on s.
    function automatic bf_addr_t bf_addr(input logic [7:0] b, input logic [3:0] s);
        bf_addr_t   r;
        logic [8:0] bw;
        logic [8:0] pos;
        logic [8:0] grp;
        bw   = {1'b0, b};
        pos  = bw & ((9'd1 << s) - 9'd1);
        grp  = bw >> s;
        r.a1 = (grp << (s + 4'd1)) | pos;
        r.a2 = r.a1 + (9'd1 << s);
        r.wn = 8'(pos << (4'($clog2(ROM_DEPTH)) - s));
        return r;
    endfunction

endpackage

// File: rtl/fft_dly_line.sv
// Fixed-latency shift register that turns the read enable/address pair into
// the matching write enable/address pair once the butterfly result is ready.
module fft_dly_line #(
    parameter int DEPTH = 2,
    parameter int W     = 19
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sr_q [DEPTH];

    // NOTE: every tap is cleared, not just the head, so writes still in flight
    // when the sequencer is reset never reach the SRAM.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
        end else begin
            sr_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sched.sv
// Sequencer for the in-place radix-2 DIT butterfly: walks every stage and
// butterfly, issuing SRAM read/write address pairs and twiddle ROM addresses.
module fft_stage_sched
    import fft_pkg::*;
#(
    parameter int BF_LAT = 2,
    parameter int AW     = AW_C,
    parameter int WAW    = WAW_C
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [1:0]     np,
    output logic           busy,
    output logic [3:0]     stage,
    output logic           rd_en,
    output logic [AW-1:0]  rd_addr1,
    output logic [AW-1:0]  rd_addr2,
    output logic           wn_rd_en,
    output logic [WAW-1:0] rd_addr_wn,
    output logic           wr_en,
    output logic [AW-1:0]  wr_addr1,
    output logic [AW-1:0]  wr_addr2,
    output logic           fft_complete
);

    localparam logic [2:0] DRAIN_LAST = 3'(BF_LAT - 1);
    localparam int         DW         = 1 + 2 * AW;

    state_e     state_q, state_d;
    logic [3:0] s_q, s_d;
    logic [3:0] m_q, m_d;
    logic [7:0] b_q, b_d;
    logic [2:0] cnt_q, cnt_d;

    logic       rd_en_q, rd_en_d;
    bf_addr_t   addr_q, addr_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [DW-1:0] wr_vec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            m_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            m_q     <= m_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        m_d     = m_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    b_d     = '0;
                    m_d     = np_to_m(np);
                end
            end
            ST_RUN: begin
                if (b_q == last_bf(m_q)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    b_d = b_q + 8'd1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    if (s_q < m_q - 4'd1) begin
                        state_d = ST_RUN;
                        s_d     = s_q + 4'd1;
                        b_d     = '0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                s_d     = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: outputs are decoded from the next state and then registered, so
    // they line up with the state register in the same cycle without comb paths.
    always_comb begin
        rd_en_d = 1'b0;
        addr_d  = '0;
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        if (state_d == ST_RUN) begin
            rd_en_d = 1'b1;
            addr_d  = bf_addr(b_d, s_d);
        end
    end

    fft_dly_line #(
        .DEPTH (BF_LAT),
        .W     (DW)
    ) u_dly (
        .clk   (clk),
        .clr_i (!rst_n),
        .d_i   ({rd_en_q, addr_q.a1, addr_q.a2}),
        .q_o   (wr_vec)
    );

    assign busy         = busy_q;
    assign stage        = s_q;
    assign rd_en        = rd_en_q;
    assign rd_addr1     = addr_q.a1;
    assign rd_addr2     = addr_q.a2;
    assign wn_rd_en     = rd_en_q;
    assign rd_addr_wn   = addr_q.wn;
    assign wr_en        = wr_vec[DW-1];
    assign wr_addr1     = wr_vec[2*AW-1:AW];
    assign wr_addr2     = wr_vec[AW-1:0];
    assign fft_complete = done_q;

endmodule
